// File: rtl/cook_timer.sv
// cook_timer: BCD MM:SS countdown timer for the magnetron path.
// A 1 Hz prescaler paces the count while the controller holds enable high.
// timer_done is a registered level that tells the controller to reset its latch.
// Optional build macro: COOK_TIMER_ADD30_EN adds an add30 strobe (+30 s, saturating at 99:59).
module cook_timer #(
  parameter int TICK_DIV = 50_000_000,
  parameter int PRE_W    = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       clearn,
  input  logic       digit_valid,
  input  logic [3:0] digit,
`ifdef COOK_TIMER_ADD30_EN
  input  logic       add30,
`endif
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       timer_done,
  output logic       tick
);

  logic [PRE_W-1:0] pre;
  logic [3:0]       nxt_mt, nxt_mo, nxt_st, nxt_so;
  logic             count_zero, run, wrap, digit_ok, dec_hit, add_hit;

  assign count_zero = (min_tens == 4'd0) && (min_ones == 4'd0) &&
                      (sec_tens == 4'd0) && (sec_ones == 4'd0);
  // The prescaler only advances while the magnetron is on and time is left.
  assign run      = enable && !count_zero;
  assign wrap     = run && (pre == PRE_W'(TICK_DIV - 1));
  assign digit_ok = !enable && digit_valid && (digit <= 4'd9);

`ifdef COOK_TIMER_ADD30_EN
  assign add_hit = add30;

  logic [6:0] sec_bin, min_bin, sec_norm;
  logic [7:0] sec_sum, min_sum;
  logic [1:0] carry;

  // Binary 0..99 to two BCD digits.
  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    return {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction

  // Add 30 s in binary, normalise seconds mod 60 (entry may be up to 99 s,
  // so up to two minutes can carry), then saturate at 99:59.
  always_comb begin
    sec_bin  = 7'(sec_tens) * 7'd10 + 7'(sec_ones);
    min_bin  = 7'(min_tens) * 7'd10 + 7'(min_ones);
    sec_sum  = 8'(sec_bin) + 8'd30;
    carry    = 2'd0;
    sec_norm = sec_sum[6:0];
    if (sec_sum >= 8'd120) begin
      carry    = 2'd2;
      sec_norm = 7'(sec_sum - 8'd120);
    end else if (sec_sum >= 8'd60) begin
      carry    = 2'd1;
      sec_norm = 7'(sec_sum - 8'd60);
    end
    min_sum = 8'(min_bin) + 8'(carry);
  end
`else
  assign add_hit = 1'b0;
`endif

  // A tick that coincides with add30 is swallowed; the prescaler still wraps.
  assign dec_hit = wrap && !add_hit;

  // Next displayed count: add30 > digit shift > BCD borrow-chain decrement.
  always_comb begin
    nxt_mt = min_tens;
    nxt_mo = min_ones;
    nxt_st = sec_tens;
    nxt_so = sec_ones;
`ifdef COOK_TIMER_ADD30_EN
    if (add_hit) begin
      if (min_sum > 8'd99) begin
        {nxt_mt, nxt_mo} = 8'h99;
        {nxt_st, nxt_so} = 8'h59;
      end else begin
        {nxt_mt, nxt_mo} = to_bcd(min_sum[6:0]);
        {nxt_st, nxt_so} = to_bcd(sec_norm);
      end
    end else
`endif
    if (digit_ok) begin
      nxt_mt = min_ones;
      nxt_mo = sec_tens;
      nxt_st = sec_ones;
      nxt_so = digit;
    end else if (dec_hit) begin
      if (sec_ones != 4'd0) begin
        nxt_so = sec_ones - 4'd1;
      end else if (sec_tens != 4'd0) begin
        nxt_st = sec_tens - 4'd1;
        nxt_so = 4'd9;
      end else if (min_ones != 4'd0) begin
        nxt_mo = min_ones - 4'd1;
        nxt_st = 4'd5;
        nxt_so = 4'd9;
      end else if (min_tens != 4'd0) begin
        nxt_mt = min_tens - 4'd1;
        nxt_mo = 4'd9;
        nxt_st = 4'd5;
        nxt_so = 4'd9;
      end
    end
  end

  // Count, done flag, tick pulse and prescaler all update on the same edge.
  always_ff @(posedge clk) begin
    if (reset || !clearn) begin
      min_tens   <= 4'd0;
      min_ones   <= 4'd0;
      sec_tens   <= 4'd0;
      sec_ones   <= 4'd0;
      pre        <= '0;
      tick       <= 1'b0;
      timer_done <= 1'b1;
    end else begin
      min_tens   <= nxt_mt;
      min_ones   <= nxt_mo;
      sec_tens   <= nxt_st;
      sec_ones   <= nxt_so;
      timer_done <= ({nxt_mt, nxt_mo, nxt_st, nxt_so} == 16'h0000);
      tick       <= dec_hit;
      if (digit_ok && !add_hit)
        pre <= '0;
      else if (run)
        pre <= wrap ? '0 : pre + PRE_W'(1);
    end
  end

endmodule

// File: tb/tb_cook_timer.sv
// tb_cook_timer: directed bench for cook_timer with TICK_DIV=4.
// A minutes/seconds integer model is compared against the DUT every cycle,
// and literal MM:SS expectations pin both the model and the DUT at key points.
module tb_cook_timer;
  localparam int TICK_DIV = 4;
  localparam int PRE_W    = 3;

  logic       clk = 1'b0;
  logic       reset, enable, clearn, digit_valid;
  logic [3:0] digit;
  logic       add30;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       timer_done, tick;

  int n_cmp = 0;
  int n_err = 0;

  cook_timer #(.TICK_DIV(TICK_DIV), .PRE_W(PRE_W)) dut (
    .clk(clk), .reset(reset), .enable(enable), .clearn(clearn),
    .digit_valid(digit_valid), .digit(digit),
`ifdef COOK_TIMER_ADD30_EN
    .add30(add30),
`endif
    .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens),
    .sec_ones(sec_ones), .timer_done(timer_done), .tick(tick)
  );

  always #5 clk = ~clk;

  // Model state: whole minutes and seconds as plain integers.
  int m_min = 0, m_sec = 0, m_pre = 0;
  bit m_tick = 1'b0, m_done = 1'b1, started = 1'b0;

  function automatic logic [15:0] bcd4(input int mm, input int ss);
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  // Model: one step per clock from the inputs sampled at the edge.
  always @(posedge clk) begin : model
    int nm, ns, np, tot, val;
    bit nt, add_now;
    nm = m_min; ns = m_sec; np = m_pre; nt = 1'b0;
    add_now = 1'b0;
`ifdef COOK_TIMER_ADD30_EN
    add_now = add30;
`endif
    if (reset || !clearn) begin
      nm = 0; ns = 0; np = 0;
    end else begin
      if (add_now) begin
        tot = m_min * 60 + m_sec + 30;
        nm = tot / 60; ns = tot % 60;
        if (nm > 99) begin nm = 99; ns = 59; end
      end else if (!enable && digit_valid && digit <= 9) begin
        val = ((m_min * 100 + m_sec) * 10 + int'(digit)) % 10000;
        nm = val / 100; ns = val % 100; np = 0;
      end
      if (enable && (m_min != 0 || m_sec != 0)) begin
        if (m_pre == TICK_DIV - 1) begin
          np = 0;
          if (!add_now) begin
            nt = 1'b1;
            if (ns > 0) ns = ns - 1;
            else begin nm = nm - 1; ns = 59; end
          end
        end else np = m_pre + 1;
      end
    end
    m_min   <= nm;
    m_sec   <= ns;
    m_pre   <= np;
    m_tick  <= nt;
    m_done  <= (nm == 0 && ns == 0);
    started <= 1'b1;
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    if (started) begin
      n_cmp++;
      if ({min_tens, min_ones, sec_tens, sec_ones} !== bcd4(m_min, m_sec) ||
          timer_done !== m_done || tick !== m_tick) begin
        n_err++;
        $display("FAIL cycle_cmp t=%0t got %h done=%b tick=%b want %h done=%b tick=%b",
                 $time, {min_tens, min_ones, sec_tens, sec_ones}, timer_done, tick,
                 bcd4(m_min, m_sec), m_done, m_tick);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic key(input logic [3:0] d);
    digit_valid = 1'b1; digit = d;
    cyc(1);
    digit_valid = 1'b0; digit = 4'd0;
  endtask

  task automatic clear();
    clearn = 1'b0;
    cyc(1);
    clearn = 1'b1;
  endtask

  // Literal check of display, done and tick; also pins the model display.
  task automatic chk(input string name, input logic [15:0] disp, input logic done,
                     input logic tk);
    n_cmp++;
    if ({min_tens, min_ones, sec_tens, sec_ones} !== disp || timer_done !== done ||
        tick !== tk) begin
      n_err++;
      $display("FAIL %s got %h done=%b tick=%b want %h done=%b tick=%b", name,
               {min_tens, min_ones, sec_tens, sec_ones}, timer_done, tick, disp, done, tk);
    end
    n_cmp++;
    if (bcd4(m_min, m_sec) !== disp) begin
      n_err++;
      $display("FAIL %s_model got %h want %h", name, bcd4(m_min, m_sec), disp);
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; clearn = 1'b1; digit_valid = 1'b0;
    digit = 4'd0; add30 = 1'b0;
    cyc(2);
    chk("reset", 16'h0000, 1'b1, 1'b0);
    reset = 1'b0;

    // Digit entry and invalid digit
    key(4'd1);  chk("first_digit", 16'h0001, 1'b0, 1'b0);
    key(4'd3);  key(4'd0);
    chk("entry_0130", 16'h0130, 1'b0, 1'b0);
    key(4'd12); chk("digit_12_ignored", 16'h0130, 1'b0, 1'b0);

    // Countdown with borrows
    enable = 1'b1;
    cyc(3);   chk("pre_tick", 16'h0130, 1'b0, 1'b0);
    cyc(1);   chk("first_tick", 16'h0129, 1'b0, 1'b1);
    cyc(1);   chk("tick_one_cycle", 16'h0129, 1'b0, 1'b0);
    cyc(115); chk("at_0100", 16'h0100, 1'b0, 1'b1);
    cyc(4);   chk("borrow_0059", 16'h0059, 1'b0, 1'b1);
    cyc(196); chk("at_0010", 16'h0010, 1'b0, 1'b1);
    cyc(4);   chk("borrow_0009", 16'h0009, 1'b0, 1'b1);
    enable = 1'b0;
    clear();  chk("clear_idle", 16'h0000, 1'b1, 1'b0);

    // Count to zero and hold
    key(4'd2);
    enable = 1'b1;
    cyc(4);   chk("at_0001", 16'h0001, 1'b0, 1'b1);
    cyc(4);   chk("done_rise", 16'h0000, 1'b1, 1'b1);
    cyc(10);  chk("hold_zero", 16'h0000, 1'b1, 1'b0);
    enable = 1'b0;

    // Pause keeps partial second; strobe while running ignored
    key(4'd5);
    enable = 1'b1;
    cyc(6);   chk("pause_start", 16'h0004, 1'b0, 1'b0);
    enable = 1'b0;
    cyc(20);  chk("paused", 16'h0004, 1'b0, 1'b0);
    enable = 1'b1;
    cyc(1);   chk("resume_1", 16'h0004, 1'b0, 1'b0);
    cyc(1);   chk("resume_tick", 16'h0003, 1'b0, 1'b1);
    key(4'd7); chk("key_while_on", 16'h0003, 1'b0, 1'b0);
    enable = 1'b0;
    clear();

    // Seconds above 59 count down natively
    key(4'd9); key(4'd0);
    enable = 1'b1;
    cyc(8);   chk("native_0088", 16'h0088, 1'b0, 1'b1);
    enable = 1'b0;
    clear();

    // Clear while counting
    key(4'd4); key(4'd7);
    enable = 1'b1;
    cyc(5);   chk("pre_clear", 16'h0046, 1'b0, 1'b0);
    clearn = 1'b0;
    cyc(1);   chk("clear_running", 16'h0000, 1'b1, 1'b0);
    clearn = 1'b1;
    enable = 1'b0;
    cyc(1);

`ifdef COOK_TIMER_ADD30_EN
    key(4'd4); key(4'd5);
    add30 = 1'b1; cyc(1); add30 = 1'b0;
    chk("add30_0115", 16'h0115, 1'b0, 1'b0);
    key(4'd9); key(4'd9); key(4'd4); key(4'd0);
    chk("load_9940", 16'h9940, 1'b0, 1'b0);
    add30 = 1'b1; cyc(1); add30 = 1'b0;
    chk("add30_sat", 16'h9959, 1'b0, 1'b0);
    clear();
    key(4'd1);
    enable = 1'b1;
    cyc(3);
    add30 = 1'b1; cyc(1); add30 = 1'b0;
    chk("add30_over_tick", 16'h0031, 1'b0, 1'b0);
    cyc(4);   chk("after_add_tick", 16'h0030, 1'b0, 1'b1);
    enable = 1'b0;
    clear();
`endif

    cyc(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
